// File: rtl/multicycle_alu_if.sv
// Operation request and result bundle for multicycle_alu.
// The master issues operations and the slave (the ALU) returns results.
interface multicycle_alu_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
);
  logic               start;
  logic [4:0]         alu_control;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [SHAMT_W-1:0] shift_amount;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   alu_result;
  logic               zero;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               div_by_zero;

  modport master (
    output start, alu_control, a, b, shift_amount,
    input  busy, done, alu_result, zero, hi, lo, div_by_zero
  );

  modport slave (
    input  start, alu_control, a, b, shift_amount,
    output busy, done, alu_result, zero, hi, lo, div_by_zero
  );
endinterface

// File: rtl/multicycle_alu.sv
// Clocked ALU: single-cycle ALU/shift ops plus iterative shift-add multiply and
// restoring divide into architectural Hi/Lo, with a start/busy/done handshake.
module multicycle_alu #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input logic             clk,
  input logic             rst_n,
  multicycle_alu_if.slave bus
);

  localparam logic [4:0] OpAdd   = 5'd0,  OpSub  = 5'd1,  OpAnd   = 5'd2,  OpOr    = 5'd3;
  localparam logic [4:0] OpXor   = 5'd4,  OpNor  = 5'd5,  OpSll   = 5'd6,  OpSrl   = 5'd7;
  localparam logic [4:0] OpSra   = 5'd8,  OpRotr = 5'd9,  OpSlt   = 5'd10, OpSltu  = 5'd11;
  localparam logic [4:0] OpSllv  = 5'd12, OpSrlv = 5'd13, OpSrav  = 5'd14, OpRotrv = 5'd15;
  localparam logic [4:0] OpMult  = 5'd16, OpDivu = 5'd19, OpMfhi  = 5'd20, OpMflo  = 5'd21;
  localparam logic [4:0] OpMthi  = 5'd22, OpMtlo = 5'd23;

  typedef enum logic [1:0] {StIdle, StPrep, StIter, StFix} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, m_q, rem_q, quo_q;
  logic [1:0]         op_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [WIDTH-1:0]   result_q, hi_q, lo_q;
  logic               zero_q, done_q, dbz_q;

  logic accept, multi_op, last_iter;
  logic is_div, sgn, a_neg, neg, b_zero;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign accept    = bus.start && (state_q == StIdle || state_q == StFix);
  assign multi_op  = (bus.alu_control >= OpMult) && (bus.alu_control <= OpDivu);
  assign last_iter = (state_q == StIter) && (cnt_q == SHAMT_W'(WIDTH - 1));

  // Latched op: bit 1 selects divide, bit 0 selects the unsigned variant.
  assign is_div = op_q[1];
  assign sgn    = !op_q[0];
  assign a_neg  = sgn && a_q[WIDTH-1];
  assign neg    = sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
  assign b_zero = (b_q == '0);
  assign mag_a  = a_neg ? -a_q : a_q;
  assign mag_b  = (sgn && b_q[WIDTH-1]) ? -b_q : b_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StFix: state_d = (accept && multi_op) ? StPrep : StIdle;
      StPrep:        state_d = StIter;
      StIter:        if (last_iter) state_d = StFix;
      default:       state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  logic [SHAMT_W-1:0] amt;
  logic [WIDTH-1:0]   rot, sc_result;

  always_comb begin
    amt       = (bus.alu_control >= OpSllv) ? bus.a[SHAMT_W-1:0] : bus.shift_amount;
    rot       = WIDTH'({bus.b, bus.b} >> amt);
    sc_result = '0;
    case (bus.alu_control)
      OpAdd:           sc_result = bus.a + bus.b;
      OpSub:           sc_result = bus.a - bus.b;
      OpAnd:           sc_result = bus.a & bus.b;
      OpOr:            sc_result = bus.a | bus.b;
      OpXor:           sc_result = bus.a ^ bus.b;
      OpNor:           sc_result = ~(bus.a | bus.b);
      OpSll, OpSllv:   sc_result = bus.b << amt;
      OpSrl, OpSrlv:   sc_result = bus.b >> amt;
      OpSra, OpSrav:   sc_result = $signed(bus.b) >>> amt;
      OpRotr, OpRotrv: sc_result = rot;
      OpSlt:           sc_result = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      OpSltu:          sc_result = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
      OpMfhi:          sc_result = hi_q;
      OpMflo:          sc_result = lo_q;
      OpMthi, OpMtlo:  sc_result = bus.a;
      default:         sc_result = '0;
    endcase
  end

  // One iteration step. Multiply keeps {rem, quo} as the partial product with the
  // multiplier shifting out of quo; divide shifts the dividend out of quo into rem.
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH-1:0]   div_diff, rem_n, quo_n, fin_hi, fin_lo;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    mul_sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
    div_shift = {rem_q, quo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, m_q};
    div_diff  = div_shift[WIDTH-1:0] - m_q;
    if (is_div) begin
      rem_n = div_ge ? div_diff : div_shift[WIDTH-1:0];
      quo_n = {quo_q[WIDTH-2:0], div_ge};
    end else begin
      rem_n = mul_sum[WIDTH:1];
      quo_n = {mul_sum[0], quo_q[WIDTH-1:1]};
    end
    prod = neg ? -{rem_n, quo_n} : {rem_n, quo_n};
    if (!is_div) begin
      {fin_hi, fin_lo} = prod;
    end else if (b_zero) begin
      fin_hi = a_q;
      fin_lo = '1;
    end else begin
      fin_hi = a_neg ? -rem_n : rem_n;
      fin_lo = neg ? -quo_n : quo_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      m_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      if (accept) begin
        if (multi_op) begin
          a_q  <= bus.a;
          b_q  <= bus.b;
          op_q <= bus.alu_control[1:0];
        end else begin
          result_q <= sc_result;
          zero_q   <= (sc_result == '0);
          done_q   <= 1'b1;
          if (bus.alu_control == OpMthi) hi_q <= bus.a;
          if (bus.alu_control == OpMtlo) lo_q <= bus.a;
        end
      end
      case (state_q)
        StPrep: begin
          m_q   <= is_div ? mag_b : mag_a;
          quo_q <= is_div ? mag_a : mag_b;
          rem_q <= '0;
          cnt_q <= '0;
        end
        StIter: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            hi_q     <= fin_hi;
            lo_q     <= fin_lo;
            result_q <= fin_lo;
            zero_q   <= (fin_lo == '0);
            done_q   <= 1'b1;
            dbz_q    <= is_div && b_zero;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state_q == StPrep) || (state_q == StIter);
  assign bus.done        = done_q;
  assign bus.alu_result  = result_q;
  assign bus.zero        = zero_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: scoreboard of expected results, one
// task per feature, outputs sampled on the falling clock edge.
module tb_multicycle_alu;
  localparam int unsigned W = 32;

  localparam logic [4:0] OpAdd   = 5'd0,  OpSub  = 5'd1,  OpAnd   = 5'd2,  OpOr    = 5'd3;
  localparam logic [4:0] OpXor   = 5'd4,  OpNor  = 5'd5,  OpSll   = 5'd6,  OpSrl   = 5'd7;
  localparam logic [4:0] OpSra   = 5'd8,  OpRotr = 5'd9,  OpSlt   = 5'd10, OpSltu  = 5'd11;
  localparam logic [4:0] OpSllv  = 5'd12, OpSrav = 5'd14, OpRotrv = 5'd15, OpMult  = 5'd16;
  localparam logic [4:0] OpMultu = 5'd17, OpDiv  = 5'd18, OpDivu  = 5'd19, OpMfhi  = 5'd20;
  localparam logic [4:0] OpMflo  = 5'd21, OpMthi = 5'd22, OpMtlo  = 5'd23;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_alu_if #(.WIDTH(W), .SHAMT_W(5)) bus ();
  multicycle_alu #(.WIDTH(W), .SHAMT_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         zero;
    logic         dbz;
  } obs_t;

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   sh;
    logic [W-1:0] res;
  } sc_t;

  obs_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  sc_t sc_tbl[12] = '{
    '{OpAdd,   32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000},
    '{OpSub,   32'd5,        32'd5,        5'd0,  32'h00000000},
    '{OpRotr,  32'h0,        32'h80000001, 5'd1,  32'hC0000000},
    '{OpSrav,  32'd36,       32'h80000000, 5'd0,  32'hF8000000},
    '{OpSlt,   32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001},
    '{OpSltu,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000},
    '{OpSll,   32'h0,        32'h00000001, 5'd31, 32'h80000000},
    '{OpSrl,   32'h0,        32'h80000000, 5'd4,  32'h08000000},
    '{OpRotrv, 32'd8,        32'h000000FF, 5'd0,  32'hFF000000},
    '{OpSllv,  32'h21,       32'h00000003, 5'd0,  32'h00000006},
    '{5'd24,   32'd5,        32'd5,        5'd0,  32'h00000000},
    '{OpSra,   32'h0,        32'h80000000, 5'd1,  32'hC0000000}
  };

  sc_t b2b_tbl[6] = '{
    '{OpAnd, 32'hFF00FF00, 32'h0F0F0F0F, 5'd0, 32'h0F000F00},
    '{OpOr,  32'hFF00FF00, 32'h0F0F0F0F, 5'd0, 32'hFF0FFF0F},
    '{OpXor, 32'hFF00FF00, 32'h0F0F0F0F, 5'd0, 32'hF00FF00F},
    '{OpNor, 32'hFF00FF00, 32'h0F0F0F0F, 5'd0, 32'h00F000F0},
    '{OpSub, 32'd3,        32'd5,        5'd0, 32'hFFFFFFFE},
    '{OpAdd, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000}
  };

  function automatic obs_t sample();
    return {bus.alu_result, bus.hi, bus.lo, bus.zero, bus.div_by_zero};
  endfunction

  function automatic obs_t mk(input logic [W-1:0] res, input logic dbz);
    return {res, m_hi, m_lo, res == '0, dbz};
  endfunction

  function automatic logic [63:0] mul_model(input logic sgn, input logic [31:0] a, b);
    if (sgn) return {{32{a[31]}}, a} * {{32{b[31]}}, b};
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [63:0] div_model(input logic sgn, input logic [31:0] a, b);
    logic signed [31:0] sa_v, sb_v, q, r;
    if (b == 0) return {a, 32'hFFFFFFFF};
    if (!sgn) return {a % b, a / b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
    sa_v = a;
    sb_v = b;
    q = sa_v / sb_v;
    r = sa_v % sb_v;
    return {r, q};
  endfunction

  task automatic drive(input logic [4:0] op, input logic [W-1:0] a, b, input logic [4:0] sh);
    bus.alu_control  = op;
    bus.a            = a;
    bus.b            = b;
    bus.shift_amount = sh;
    bus.start        = 1'b1;
  endtask

  // Issues one op and waits (bounded) for Done; returns Done cycle (0 on timeout).
  task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, b, input logic [4:0] sh,
                        output int cyc, output int bcyc, output obs_t obs);
    @(negedge clk);
    drive(op, a, b, sh);
    cyc  = 0;
    bcyc = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy) bcyc++;
      if (bus.done) begin
        cyc = i;
        break;
      end
    end
    obs = sample();
  endtask

  task automatic test_reset();
    logic [99:0] got;
    bus.start = 1'b0;
    bus.alu_control = '0;
    bus.a = '0;
    bus.b = '0;
    bus.shift_amount = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    got = {bus.busy, bus.done, sample()};
    n_cmp++;
    if (got !== '0) begin
      n_err++;
      $display("FAIL reset_state: got %h expected 0", got);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int cyc, bcyc;
    obs_t obs, e;
    foreach (sc_tbl[k]) begin
      sb.push_back(mk(sc_tbl[k].res, 1'b0));
      run_op(sc_tbl[k].op, sc_tbl[k].a, sc_tbl[k].b, sc_tbl[k].sh, cyc, bcyc, obs);
      e = sb.pop_front();
      n_cmp++;
      if (cyc !== 1 || bcyc !== 0) begin
        n_err++;
        $display("FAIL single_latency[%0d]: got done_cycle=%0d busy_cycles=%0d expected 1/0",
                 k, cyc, bcyc);
      end
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL single_result[%0d]: got res=%h hi=%h lo=%h z=%b dbz=%b expected res=%h hi=%h lo=%h z=%b dbz=%b",
                 k, obs.res, obs.hi, obs.lo, obs.zero, obs.dbz, e.res, e.hi, e.lo, e.zero, e.dbz);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t obs, e;
    logic d;
    @(negedge clk);
    drive(b2b_tbl[0].op, b2b_tbl[0].a, b2b_tbl[0].b, b2b_tbl[0].sh);
    sb.push_back(mk(b2b_tbl[0].res, 1'b0));
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      obs = sample();
      d = bus.done;
      if (i < 6) begin
        drive(b2b_tbl[i].op, b2b_tbl[i].a, b2b_tbl[i].b, b2b_tbl[i].sh);
        sb.push_back(mk(b2b_tbl[i].res, 1'b0));
      end else begin
        bus.start = 1'b0;
      end
      e = sb.pop_front();
      n_cmp++;
      if (d !== 1'b1 || obs !== e) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got done=%b res=%h z=%b expected done=1 res=%h z=%b",
                 i - 1, d, obs.res, obs.zero, e.res, e.zero);
      end
    end
  endtask

  task automatic do_mul(input string name, input logic sgn, input logic [W-1:0] a, b);
    int cyc, bcyc;
    obs_t obs, e;
    logic [63:0] p;
    p = mul_model(sgn, a, b);
    m_hi = p[63:32];
    m_lo = p[31:0];
    sb.push_back(mk(m_lo, 1'b0));
    run_op(sgn ? OpMult : OpMultu, a, b, 5'd0, cyc, bcyc, obs);
    e = sb.pop_front();
    n_cmp++;
    if (cyc !== 34 || bcyc !== 33) begin
      n_err++;
      $display("FAIL %s_latency: got done_cycle=%0d busy_cycles=%0d expected 34/33", name, cyc, bcyc);
    end
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL %s: got res=%h hi=%h lo=%h z=%b expected res=%h hi=%h lo=%h z=%b",
               name, obs.res, obs.hi, obs.lo, obs.zero, e.res, e.hi, e.lo, e.zero);
    end
  endtask

  task automatic test_mult();
    do_mul("mult_neg3x7", 1'b1, 32'hFFFFFFFD, 32'd7);
    do_mul("multu_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    // MFHI issued in the Done cycle must see the new Hi.
    drive(OpMfhi, '0, '0, 5'd0);
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++;
    if (bus.done !== 1'b1 || bus.alu_result !== 32'hFFFFFFFE) begin
      n_err++;
      $display("FAIL mfhi_in_done_cycle: got done=%b res=%h expected done=1 res=fffffffe",
               bus.done, bus.alu_result);
    end
    for (int i = 0; i < 4; i++) begin
      do_mul("mult_rand", i[0], $urandom, $urandom);
    end
  endtask

  task automatic do_div(input string name, input logic sgn, input logic [W-1:0] a, b);
    int cyc, bcyc;
    obs_t obs, e;
    logic [63:0] q;
    q = div_model(sgn, a, b);
    m_hi = q[63:32];
    m_lo = q[31:0];
    sb.push_back(mk(m_lo, b == '0));
    run_op(sgn ? OpDiv : OpDivu, a, b, 5'd0, cyc, bcyc, obs);
    e = sb.pop_front();
    n_cmp++;
    if (cyc !== 34 || bcyc !== 33 || obs !== e) begin
      n_err++;
      $display("FAIL %s: got cyc=%0d res=%h hi=%h lo=%h dbz=%b expected cyc=34 res=%h hi=%h lo=%h dbz=%b",
               name, cyc, obs.res, obs.hi, obs.lo, obs.dbz, e.res, e.hi, e.lo, e.dbz);
    end
  endtask

  task automatic test_div();
    do_div("div_neg7_2", 1'b1, 32'hFFFFFFF9, 32'd2);
    do_div("divu_by_zero", 1'b0, 32'd100, 32'd0);
    @(negedge clk);
    n_cmp++;
    if (bus.div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL dbz_one_cycle: got dbz=%b expected 0", bus.div_by_zero);
    end
    do_div("div_overflow", 1'b1, 32'h80000000, 32'hFFFFFFFF);
    do_div("div_neg_by_zero", 1'b1, 32'hFFFFFFF0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      do_div("div_rand", i[0], $urandom, $urandom_range(32'hFFFFFFFF, 1));
    end
  endtask

  task automatic test_mthi_mfhi();
    int cyc, bcyc;
    obs_t obs, e;
    logic [4:0]   ops[4] = '{OpMthi, OpMfhi, OpMtlo, OpMflo};
    logic [W-1:0] as[4]  = '{32'h12345678, 32'h0, 32'hCAFEF00D, 32'h0};
    for (int i = 0; i < 4; i++) begin
      if (ops[i] == OpMthi) m_hi = as[i];
      if (ops[i] == OpMtlo) m_lo = as[i];
      sb.push_back(mk((ops[i] == OpMfhi) ? m_hi : (ops[i] == OpMflo) ? m_lo : as[i], 1'b0));
      run_op(ops[i], as[i], 32'h0, 5'd0, cyc, bcyc, obs);
      e = sb.pop_front();
      n_cmp++;
      if (cyc !== 1 || obs !== e) begin
        n_err++;
        $display("FAIL hilo_move[%0d]: got cyc=%0d res=%h hi=%h lo=%h expected cyc=1 res=%h hi=%h lo=%h",
                 i, cyc, obs.res, obs.hi, obs.lo, e.res, e.hi, e.lo);
      end
    end
  endtask

  task automatic test_busy_ignore();
    obs_t obs_done, obs_end, e;
    int ndone, dcyc;
    m_hi = 32'h0;
    m_lo = 32'd15;
    sb.push_back(mk(32'd15, 1'b0));
    @(negedge clk);
    drive(OpMult, 32'd3, 32'd5, 5'd0);
    ndone = 0;
    dcyc = 0;
    obs_done = '0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        if (dcyc == 0) begin
          dcyc = i;
          obs_done = sample();
        end
      end
      if (i == 3) drive(OpAdd, 32'd1, 32'd2, 5'd0);
      else bus.start = 1'b0;
    end
    obs_end = sample();
    e = sb.pop_front();
    n_cmp++;
    if (ndone !== 1 || dcyc !== 34) begin
      n_err++;
      $display("FAIL busy_ignore_done: got dones=%0d first_cycle=%0d expected 1/34", ndone, dcyc);
    end
    n_cmp++;
    if (obs_done !== e || obs_end !== e) begin
      n_err++;
      $display("FAIL busy_ignore_result: got res=%h hi=%h lo=%h (end res=%h) expected res=%h hi=%h lo=%h",
               obs_done.res, obs_done.hi, obs_done.lo, obs_end.res, e.res, e.hi, e.lo);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [99:0] got;
    int ndone;
    @(negedge clk);
    drive(OpMult, 32'h1234, 32'h5678, 5'd0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1 got = {bus.busy, bus.done, sample()};
    m_hi = '0;
    m_lo = '0;
    n_cmp++;
    if (got !== '0) begin
      n_err++;
      $display("FAIL reset_mid_op: got %h expected 0", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    n_cmp++;
    if (ndone !== 0) begin
      n_err++;
      $display("FAIL reset_no_done: got dones=%0d expected 0", ndone);
    end
    do_mul("mult_after_reset", 1'b1, 32'h1234, 32'h5678);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_mult();
    test_div();
    test_mthi_mfhi();
    test_busy_ignore();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
